// File: rtl/fft_pkg.sv
// Shared widths, twiddle table and controller states for the 8-point DIT FFT final stage.
package fft_pkg;

  localparam int IN_W    = 50;  // Q22.28
  localparam int OUT_W   = 67;  // Q25.42
  localparam int TW_W    = 16;  // Q2.14
  localparam int TW_FRAC = 14;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  // W8^k = exp(-j*2*pi*k/8), k = 0..3
  localparam tw_t W8 [0:3] = '{
    '{re:  16'sd16384, im:  16'sd0},
    '{re:  16'sd11585, im: -16'sd11585},
    '{re:  16'sd0,     im: -16'sd16384},
    '{re: -16'sd11585, im: -16'sd11585}
  };

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

endpackage

// File: rtl/Butterfly_Unit_Stage3.sv
// Combinational radix-2 DIT butterfly: out1 = a + b*w, out2 = a - b*w.
// Full-precision Q25.42 results; no rounding, saturation or truncation.
module Butterfly_Unit_Stage3
  import fft_pkg::*;
(
  input  logic signed [IN_W-1:0]  in1_real,
  input  logic signed [IN_W-1:0]  in1_imag,
  input  logic signed [IN_W-1:0]  in2_real,
  input  logic signed [IN_W-1:0]  in2_imag,
  input  logic signed [TW_W-1:0]  tw_real,
  input  logic signed [TW_W-1:0]  tw_imag,
  output logic signed [OUT_W-1:0] out1_real,
  output logic signed [OUT_W-1:0] out1_imag,
  output logic signed [OUT_W-1:0] out2_real,
  output logic signed [OUT_W-1:0] out2_imag
);

  localparam int PW = IN_W + TW_W;

  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
  logic signed [OUT_W-1:0] bw_real, bw_imag, a_real, a_imag;

  always_comb begin
    p_rr = PW'(in2_real) * PW'(tw_real);
    p_ii = PW'(in2_imag) * PW'(tw_imag);
    p_ri = PW'(in2_real) * PW'(tw_imag);
    p_ir = PW'(in2_imag) * PW'(tw_real);
    bw_real = OUT_W'(p_rr) - OUT_W'(p_ii);
    bw_imag = OUT_W'(p_ri) + OUT_W'(p_ir);
    // Align the untwiddled operand from 28 to 42 fractional bits.
    a_real = OUT_W'(in1_real) <<< TW_FRAC;
    a_imag = OUT_W'(in1_imag) <<< TW_FRAC;
    out1_real = a_real + bw_real;
    out1_imag = a_imag + bw_imag;
    out2_real = a_real - bw_real;
    out2_imag = a_imag - bw_imag;
  end

endmodule

// File: rtl/fft8_stage3_ctrl.sv
// Final radix-2 stage sequencer: buffers 8 inputs, runs 4 butterflies, streams X[0..7] out.
// First output 5 cycles after the last input handshake; holds output stable while out_ready is low.
module fft8_stage3_ctrl
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag,
  output logic [2:0]              out_index,
  output logic                    out_last,
  output logic                    busy
);

  state_t     state, state_nxt;
  logic [2:0] wr_cnt, wr_cnt_nxt;
  logic [2:0] rd_cnt, rd_cnt_nxt;
  logic [1:0] bf_cnt, bf_cnt_nxt;

  logic signed [IN_W-1:0]  ibuf_re [0:7];
  logic signed [IN_W-1:0]  ibuf_im [0:7];
  logic signed [OUT_W-1:0] obuf_re [0:7];
  logic signed [OUT_W-1:0] obuf_im [0:7];

  tw_t                     tw;
  logic signed [OUT_W-1:0] bf1_re, bf1_im, bf2_re, bf2_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_cnt <= 3'd0;
      bf_cnt <= 2'd0;
      rd_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      bf_cnt <= bf_cnt_nxt;
      rd_cnt <= rd_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    bf_cnt_nxt = bf_cnt;
    rd_cnt_nxt = rd_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_cnt_nxt = wr_cnt + 3'd1;
          if (wr_cnt == 3'd7) begin
            state_nxt  = COMPUTE;
            bf_cnt_nxt = 2'd0;
          end
        end
      end
      COMPUTE: begin
        busy       = 1'b1;
        bf_cnt_nxt = bf_cnt + 2'd1;
        if (bf_cnt == 2'd3) begin
          state_nxt  = UNLOAD;
          rd_cnt_nxt = 3'd0;
        end
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          rd_cnt_nxt = rd_cnt + 3'd1;
          if (rd_cnt == 3'd7) begin
            state_nxt  = LOAD;
            wr_cnt_nxt = 3'd0;
            rd_cnt_nxt = 3'd0;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    tw = W8[0];
    case (bf_cnt)
      2'd0: tw = W8[0];
      2'd1: tw = W8[1];
      2'd2: tw = W8[2];
      2'd3: tw = W8[3];
    endcase
  end

  Butterfly_Unit_Stage3 u_bf (
    .in1_real  (ibuf_re[{1'b0, bf_cnt}]),
    .in1_imag  (ibuf_im[{1'b0, bf_cnt}]),
    .in2_real  (ibuf_re[{1'b1, bf_cnt}]),
    .in2_imag  (ibuf_im[{1'b1, bf_cnt}]),
    .tw_real   (tw.re),
    .tw_imag   (tw.im),
    .out1_real (bf1_re),
    .out1_imag (bf1_im),
    .out2_real (bf2_re),
    .out2_imag (bf2_im)
  );

  // Frame buffers carry no reset: a restarted frame overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      ibuf_re[wr_cnt] <= in_real;
      ibuf_im[wr_cnt] <= in_imag;
    end
    if (state == COMPUTE) begin
      obuf_re[{1'b0, bf_cnt}] <= bf1_re;
      obuf_im[{1'b0, bf_cnt}] <= bf1_im;
      obuf_re[{1'b1, bf_cnt}] <= bf2_re;
      obuf_im[{1'b1, bf_cnt}] <= bf2_im;
    end
  end

  assign out_real  = out_valid ? obuf_re[rd_cnt] : '0;
  assign out_imag  = out_valid ? obuf_im[rd_cnt] : '0;
  assign out_index = rd_cnt;
  assign out_last  = out_valid && (rd_cnt == 3'd7);

endmodule

// File: tb/tb_fft8_stage3_ctrl.sv
// Randomized scoreboard bench for the final FFT stage sequencer.
module tb_fft8_stage3_ctrl;

  localparam int IN_W  = 50;
  localparam int OUT_W = 67;

  typedef logic signed [127:0] big_t;
  typedef struct {
    big_t re;
    big_t im;
    int   idx;
    bit   last;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_real = '0;
  logic signed [IN_W-1:0]  in_imag = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_real;
  logic signed [OUT_W-1:0] out_imag;
  logic [2:0]              out_index;
  logic                    out_last;
  logic                    busy;

  fft8_stage3_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  logic signed [IN_W-1:0] fr_re [8];
  logic signed [IN_W-1:0] fr_im [8];
  int first_hs = 0;
  int last_hs = 0;
  bit lat_pending = 1'b0;
  int rdy_mode = 0;

  int tw_re [4] = '{16384, 11585, 0, -11585};
  int tw_im [4] = '{0, -11585, -16384, -11585};

  task automatic chk(input string name, input big_t act, input big_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // X[b] = a[b%4] + sgn * a[b%4+4] * W8^(b%4); input LSB 2^-28, output LSB 2^-42.
  task automatic push_expected();
    for (int b = 0; b < 8; b++) begin
      int   k;
      big_t a_re, a_im, c_re, c_im, p_re, p_im;
      exp_t e;
      k = b % 4;
      a_re = big_t'(fr_re[k]) * 16384;
      a_im = big_t'(fr_im[k]) * 16384;
      c_re = big_t'(fr_re[k+4]);
      c_im = big_t'(fr_im[k+4]);
      p_re = c_re * tw_re[k] - c_im * tw_im[k];
      p_im = c_re * tw_im[k] + c_im * tw_re[k];
      e.re   = (b < 4) ? a_re + p_re : a_re - p_re;
      e.im   = (b < 4) ? a_im + p_im : a_im - p_im;
      e.idx  = b;
      e.last = (b == 7);
      sb.push_back(e);
    end
  endtask

  function automatic logic signed [IN_W-1:0] rnd50();
    logic [63:0]            r;
    logic signed [IN_W-1:0] v;
    r = {$urandom, $urandom};
    v = '0;
    case ($urandom_range(0, 5))
      3: v = IN_W'($signed(r[19:0]));
      4: v[IN_W-1] = 1'b1;
      5: begin v = '1; v[IN_W-1] = 1'b0; end
      default: v = r[IN_W-1:0];
    endcase
    return v;
  endfunction

  task automatic rand_frame();
    for (int n = 0; n < 8; n++) begin
      fr_re[n] = rnd50();
      fr_im[n] = rnd50();
    end
  endtask

  task automatic clear_frame();
    for (int n = 0; n < 8; n++) begin
      fr_re[n] = '0;
      fr_im[n] = '0;
    end
  endtask

  // Entered and left just after a rising edge; in_valid stays high on return.
  task automatic send_frame(input bit gaps);
    for (int n = 0; n < 8; n++) begin
      int w;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_real  = rnd50();
          in_imag  = rnd50();
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_real  = fr_re[n];
      in_imag  = fr_im[n];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout word=%0d actual=0 required=1", n);
      end
      if (n == 0) first_hs = cyc + 1;
      if (n == 7) begin
        last_hs = cyc + 1;
        lat_pending = 1'b1;
        push_expected();
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin
          out_ready = (ph == 0 || ph == 3);
          ph = (ph + 1) % 4;
        end
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    bit                      vld_prev, stall_prev, expect_load;
    logic signed [OUT_W-1:0] h_re, h_im;
    logic [2:0]              h_idx;
    exp_t                    e;
    vld_prev = 0;
    stall_prev = 0;
    expect_load = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vld_prev = 0;
        stall_prev = 0;
        expect_load = 0;
      end else begin
        if (expect_load) begin
          chk("in_ready_after_frame", in_ready, 1);
          chk("busy_after_frame", busy, 0);
          expect_load = 0;
        end
        if (out_valid) begin
          if (!vld_prev && lat_pending) begin
            chk("first_out_latency", cyc - last_hs + 1, 5);
            lat_pending = 1'b0;
          end
          if (stall_prev) begin
            chk("stall_hold_real", out_real, h_re);
            chk("stall_hold_imag", out_imag, h_im);
            chk("stall_hold_index", out_index, h_idx);
          end
          chk("in_ready_busy_unload", {in_ready, busy}, 1);
          if (out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output actual_index=%0d required=no_output", out_index);
            end else begin
              e = sb.pop_front();
              chk("out_real", out_real, e.re);
              chk("out_imag", out_imag, e.im);
              chk("out_index", out_index, e.idx);
              chk("out_last", out_last, e.last);
              if (e.last) expect_load = 1;
            end
          end
          stall_prev = !out_ready;
          h_re  = out_real;
          h_im  = out_imag;
          h_idx = out_index;
        end else begin
          stall_prev = 0;
        end
        vld_prev = out_valid;
      end
    end
  end

  initial begin
    int sa, sb_start;
    logic signed [IN_W-1:0] mn;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse on sample 4 and on sample 5.
    clear_frame();
    fr_re[4] = 50'sh10000000;
    send_frame(0);
    in_valid = 1'b0;
    drain();
    clear_frame();
    fr_re[5] = 50'sh10000000;
    send_frame(0);
    in_valid = 1'b0;
    drain();

    // Output backpressure 1,0,0,1 with input gaps.
    rdy_mode = 1;
    rand_frame();
    send_frame(1);
    in_valid = 1'b0;
    drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Back-to-back frames, in_valid held high across the boundary.
    rand_frame();
    send_frame(0);
    sa = first_hs;
    rand_frame();
    send_frame(0);
    sb_start = first_hs;
    in_valid = 1'b0;
    chk("frame_period", sb_start - sa, 20);
    drain();

    // Full-scale negative inputs.
    mn = '0;
    mn[IN_W-1] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      fr_re[n] = mn;
      fr_im[n] = mn;
    end
    send_frame(0);
    in_valid = 1'b0;
    drain();

    // Random frames under random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(1);
    end
    in_valid = 1'b0;
    drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset during the second compute cycle, then a clean frame.
    rand_frame();
    send_frame(0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_compute", {in_ready, busy, out_valid}, 2);
    #1 rst_n = 1'b0;
    sb.delete();
    lat_pending = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_index", out_index, 0);
    chk("arst_out_real", out_real, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_frame();
    send_frame(1);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
